// File: rtl/fp_normalize_if.sv
// Handshake and data bundle for the fp_normalize stage.
//   master : upstream/downstream side (drives operand, in_valid, out_ready)
//   slave  : the normalizer (drives in_ready, result, flags, shift_count)
interface fp_normalize_if #(
    parameter int unsigned EXP_W  = 11,
    parameter int unsigned FRAC_W = 52
);
    localparam int unsigned MANT_W = FRAC_W + 2;
    localparam int unsigned RES_W  = 1 + EXP_W + FRAC_W;

    logic              in_valid;
    logic              in_ready;
    logic              in_sign;
    logic [EXP_W-1:0]  in_exponent;
    logic [MANT_W-1:0] in_mantissa;
    logic              out_valid;
    logic              out_ready;
    logic [RES_W-1:0]  result;
    logic              zero;
    logic              overflow;
    logic              underflow;
    logic [5:0]        shift_count;

    modport master (
        output in_valid, in_sign, in_exponent, in_mantissa, out_ready,
        input  in_ready, out_valid, result, zero, overflow, underflow, shift_count
    );

    modport slave (
        input  in_valid, in_sign, in_exponent, in_mantissa, out_ready,
        output in_ready, out_valid, result, zero, overflow, underflow, shift_count
    );
endinterface

// File: rtl/fp_normalize.sv
// Bit-serial normalizer for the FP add/sub result: shifts the raw magnitude
// into IEEE-754 normal/denormal form one bit per cycle, flags zero,
// overflow (saturate to inf) and underflow (denormal), truncating.
// Ports:
//   clock   : rising-edge clock
//   reset_n : synchronous active-low reset
//   bus     : fp_normalize_if.slave (operand in, packed result/flags out)
module fp_normalize #(
    parameter int unsigned EXP_W  = 11,
    parameter int unsigned FRAC_W = 52
) (
    input  logic           clock,
    input  logic           reset_n,
    fp_normalize_if.slave  bus
);
    localparam int unsigned MANT_W = FRAC_W + 2;
    localparam int unsigned EXPI_W = EXP_W + 1;
    localparam int unsigned RES_W  = 1 + EXP_W + FRAC_W;
    localparam int unsigned CNT_W  = 6;
    localparam logic [EXPI_W-1:0] EXP_INF = EXPI_W'((1 << EXP_W) - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} state_e;

    state_e              state_q, state_d;
    logic                sign_q, sign_d;
    logic [EXPI_W-1:0]   exp_q, exp_d;
    logic [MANT_W-1:0]   mant_q, mant_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                zero_q, zero_d;
    logic                ovf_q, ovf_d;
    logic                unf_q, unf_d;
    logic                valid_q, valid_d;
    logic [RES_W-1:0]    result_q, result_d;
    logic                finish;

    // State and datapath registers
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            sign_q   <= 1'b0;
            exp_q    <= '0;
            mant_q   <= '0;
            cnt_q    <= '0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            valid_q  <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            sign_q   <= sign_d;
            exp_q    <= exp_d;
            mant_q   <= mant_d;
            cnt_q    <= cnt_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            valid_q  <= valid_d;
            result_q <= result_d;
        end
    end

    // Next-state and normalization rules
    always_comb begin
        state_d  = state_q;
        sign_d   = sign_q;
        exp_d    = exp_q;
        mant_d   = mant_q;
        cnt_d    = cnt_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        valid_d  = valid_q;
        result_d = result_q;
        finish   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    sign_d  = bus.in_sign;
                    exp_d   = EXPI_W'(bus.in_exponent);
                    mant_d  = bus.in_mantissa;
                    cnt_d   = '0;
                    zero_d  = 1'b0;
                    ovf_d   = 1'b0;
                    unf_d   = 1'b0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (mant_q == '0) begin
                    sign_d = 1'b0;
                    exp_d  = '0;
                    zero_d = 1'b1;
                    finish = 1'b1;
                end else if (mant_q[MANT_W-1]) begin
                    // Carry out: renormalize right; saturate to inf at max exponent
                    mant_d = {1'b0, mant_q[MANT_W-1:1]};
                    exp_d  = exp_q + EXPI_W'(1);
                    if (exp_d == EXP_INF) begin
                        mant_d[FRAC_W-1:0] = '0;
                        ovf_d              = 1'b1;
                    end
                    finish = 1'b1;
                end else if (mant_q[FRAC_W]) begin
                    // Hidden bit set with exp 0 (denormal grew into normal range)
                    if (exp_q == '0) begin
                        exp_d = EXPI_W'(1);
                    end
                    finish = 1'b1;
                end else if (exp_q <= EXPI_W'(1)) begin
                    exp_d  = '0;
                    unf_d  = 1'b1;
                    finish = 1'b1;
                end else begin
                    mant_d = {mant_q[MANT_W-2:0], 1'b0};
                    exp_d  = exp_q - EXPI_W'(1);
                    cnt_d  = cnt_q + CNT_W'(1);
                end

                if (finish) begin
                    result_d = {sign_d, exp_d[EXP_W-1:0], mant_d[FRAC_W-1:0]};
                    valid_d  = 1'b1;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    valid_d = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.in_ready    = (state_q == ST_IDLE) && reset_n;
    assign bus.out_valid   = valid_q;
    assign bus.result      = result_q;
    assign bus.zero        = zero_q;
    assign bus.overflow    = ovf_q;
    assign bus.underflow   = unf_q;
    assign bus.shift_count = cnt_q;
endmodule

// File: tb/tb_fp_normalize.sv
// Self-checking bench for fp_normalize: directed test-plan operands followed by
// random operands, each compared against an arithmetic reference model.
module tb_fp_normalize;
    logic clock;
    logic reset_n;
    int   checks;
    int   errors;

    fp_normalize_if #(.EXP_W(11), .FRAC_W(52)) u_if ();

    fp_normalize #(.EXP_W(11), .FRAC_W(52)) u_dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (u_if.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("FAIL %s: observed=0x%h expected=0x%h", tag, obs, expv);
        end
    endtask

    // Reference: decide the outcome from the leading-one position and exponent headroom.
    function automatic void model(input logic s, input logic [10:0] e, input logic [53:0] m,
                                  output logic [63:0] r, output logic z, output logic o,
                                  output logic u, output int n);
        int          ee;
        int          p;
        int          need;
        logic [53:0] mm;
        ee = int'(e);
        z = 1'b0; o = 1'b0; u = 1'b0; n = 0;
        mm = m;
        if (m == 54'd0) begin
            z = 1'b1;
            r = 64'd0;
            return;
        end
        if (m[53]) begin
            ee = ee + 1;
            mm = m >> 1;
            if (ee == 2047) begin
                o  = 1'b1;
                mm = 54'd0;
            end
            r = {s, 11'(ee), mm[51:0]};
            return;
        end
        p = 0;
        for (int i = 0; i < 53; i++) if (m[i]) p = i;
        need = 52 - p;
        if (need == 0) begin
            if (ee == 0) ee = 1;
        end else if (ee <= 1) begin
            u  = 1'b1;
            ee = 0;
        end else if (need <= ee - 1) begin
            n  = need;
            ee = ee - need;
            mm = m << need;
        end else begin
            n  = ee - 1;
            mm = m << n;
            ee = 0;
            u  = 1'b1;
        end
        r = {s, 11'(ee), mm[51:0]};
    endfunction

    // Accept one operand, wait for the result, backpressure for 'hold' cycles, then hand off.
    task automatic run_op(input string name, input logic s, input logic [10:0] e,
                          input logic [53:0] m, input int hold);
        logic [63:0] er;
        logic        ez, eo, eu;
        int          en;
        int          j;
        model(s, e, m, er, ez, eo, eu, en);
        chk({name, ".in_ready_idle"}, 64'(u_if.in_ready), 64'd1);
        u_if.in_sign     = s;
        u_if.in_exponent = e;
        u_if.in_mantissa = m;
        u_if.in_valid    = 1'b1;
        @(posedge clock); #1;
        u_if.in_valid    = 1'b0;
        j = 0;
        while (u_if.out_valid !== 1'b1 && j < 80) begin
            @(posedge clock); #1;
            j++;
        end
        if (u_if.out_valid !== 1'b1) begin
            chk({name, ".timeout"}, 64'(u_if.out_valid), 64'd1);
            return;
        end
        chk({name, ".latency"}, 64'(j + 1), 64'(2 + en));
        chk({name, ".result"}, u_if.result, er);
        chk({name, ".flags"}, 64'({u_if.zero, u_if.overflow, u_if.underflow}), 64'({ez, eo, eu}));
        chk({name, ".shift_count"}, 64'(u_if.shift_count), 64'(en));
        chk({name, ".in_ready_done"}, 64'(u_if.in_ready), 64'd0);
        for (int h = 0; h < hold; h++) begin
            // Upstream presents a new operand that must be ignored while busy.
            u_if.in_valid    = 1'b1;
            u_if.in_mantissa = {$urandom, $urandom};
            @(posedge clock); #1;
            chk({name, ".hold_valid"}, 64'(u_if.out_valid), 64'd1);
            chk({name, ".hold_result"}, u_if.result, er);
            chk({name, ".hold_flags"}, 64'({u_if.zero, u_if.overflow, u_if.underflow, u_if.shift_count}),
                64'({ez, eo, eu, 6'(en)}));
            chk({name, ".hold_in_ready"}, 64'(u_if.in_ready), 64'd0);
        end
        u_if.in_valid  = 1'b0;
        u_if.out_ready = 1'b1;
        @(posedge clock); #1;
        u_if.out_ready = 1'b0;
        chk({name, ".post_valid"}, 64'(u_if.out_valid), 64'd0);
        chk({name, ".post_in_ready"}, 64'(u_if.in_ready), 64'd1);
    endtask

    initial begin
        logic [10:0] re;
        logic [53:0] rm;
        int          sel;
        checks = 0;
        errors = 0;
        reset_n          = 1'b0;
        u_if.in_valid    = 1'b0;
        u_if.in_sign     = 1'b0;
        u_if.in_exponent = '0;
        u_if.in_mantissa = '0;
        u_if.out_ready   = 1'b0;
        @(posedge clock); @(posedge clock); #1;
        chk("rst.in_ready", 64'(u_if.in_ready), 64'd0);
        chk("rst.out_valid", 64'(u_if.out_valid), 64'd0);
        chk("rst.result", u_if.result, 64'd0);
        chk("rst.flags_cnt", 64'({u_if.zero, u_if.overflow, u_if.underflow, u_if.shift_count}), 64'd0);
        reset_n = 1'b1;
        #1;

        run_op("normal", 1'b0, 11'h400, 54'h10_0000_0000_0000, 0);
        chk("normal.const", u_if.result, 64'h4000_0000_0000_0000);
        run_op("carry", 1'b0, 11'h3FF, 54'h20_0000_0000_0000, 1);
        chk("carry.const", u_if.result, 64'h4000_0000_0000_0000);
        run_op("cancel", 1'b0, 11'h400, 54'h00_8000_0000_0000, 0);
        chk("cancel.const", u_if.result, 64'h3FB0_0000_0000_0000);
        run_op("exact_zero", 1'b1, 11'h3FF, 54'h0, 0);
        chk("exact_zero.const", u_if.result, 64'h0);
        run_op("overflow", 1'b0, 11'h7FE, 54'h20_0000_0000_0000, 0);
        chk("overflow.const", u_if.result, 64'h7FF0_0000_0000_0000);
        run_op("underflow", 1'b0, 11'h002, 54'h04_0000_0000_0000, 3);
        chk("underflow.const", u_if.result, 64'h0008_0000_0000_0000);
        run_op("denorm_grow", 1'b1, 11'h000, 54'h10_0000_0000_0001, 0);
        run_op("denorm_keep", 1'b0, 11'h000, 54'h00_0000_0000_0005, 0);

        // Reset in the middle of a long shift sequence: no result may appear.
        u_if.in_sign     = 1'b0;
        u_if.in_exponent = 11'h400;
        u_if.in_mantissa = 54'h00_8000_0000_0000;
        u_if.in_valid    = 1'b1;
        @(posedge clock); #1;
        u_if.in_valid = 1'b0;
        @(posedge clock); #1;
        reset_n = 1'b0;
        @(posedge clock); #1;
        chk("midrst.out_valid", 64'(u_if.out_valid), 64'd0);
        chk("midrst.in_ready_low", 64'(u_if.in_ready), 64'd0);
        chk("midrst.cnt", 64'(u_if.shift_count), 64'd0);
        reset_n = 1'b1;
        #1;
        chk("midrst.in_ready_back", 64'(u_if.in_ready), 64'd1);
        for (int k = 0; k < 8; k++) begin
            @(posedge clock); #1;
            chk("midrst.no_output", 64'(u_if.out_valid), 64'd0);
        end

        for (int t = 0; t < 40; t++) begin
            sel = int'($urandom_range(0, 3));
            case (sel)
                0:       re = 11'($urandom_range(0, 4));
                1:       re = 11'($urandom_range(2040, 2046));
                default: re = 11'($urandom_range(0, 2046));
            endcase
            rm = 54'({$urandom, $urandom});
            rm = rm >> $urandom_range(0, 54);
            run_op($sformatf("rand%0d", t), 1'($urandom), re, rm, int'($urandom_range(0, 2)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
